fifo_wr_arbiter: RTL and testbench

//  Shares one sync_fifo write port among N_REQ producers using a valid/ready handshake.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_if.sv | 18 +
 rtl/fifo_wr_arbiter_rr.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  // Arbiter FSM: free for round-robin, or held by one producer mid-packet
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Bits needed to carry a requester index (never narrower than one bit)
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer-side valid/ready bundle for the FIFO write arbiter
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) ();

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;

  // Producers drive beats and observe ready
  modport master (output req_valid, output req_data, output req_last, input req_ready);

  // The arbiter observes beats and drives ready
  modport slave (input req_valid, input req_data, input req_last, output req_ready);

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// rtl/fifo_wr_arbiter_rr.sv - round-robin pick: masked priority encoder with unmasked fallback
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-locked round-robin sharing of one sync_fifo write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  localparam int ID_W     = id_w(N_REQ)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  fifo_wr_arbiter_if.slave      req_if,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [WIDTH+ID_W-1:0] fifo_din,
  output logic [ID_W-1:0]       grant_id,
  output logic                  locked,
  output logic                  burst_trunc
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             trunc_q, trunc_d;
  logic             en_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic [N_REQ-1:0] ready;
  logic [ID_W-1:0]  sel;
  logic             sel_ok;
  logic             xfer;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_if.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Pick the active source, gate ready on full/enable, and plan the next FSM step
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    ready      = '0;
    if (state_q == ARB_IDLE) begin
      sel      = arb_idx;
      sel_ok   = |arb_gnt;
      cnt_next = CNT_W'(1);
    end else begin
      sel      = owner_q;
      sel_ok   = 1'b1;
      cnt_next = (beat_cnt_q == CNT_MAX) ? CNT_MAX : beat_cnt_q + 1'b1;
    end
    if (en_q && sel_ok && !fifo_full) ready[sel] = 1'b1;
    xfer = |(req_if.req_valid & ready);
    if (xfer) begin
      grant_d    = sel;
      beat_cnt_d = cnt_next;
      if (req_if.req_last[sel] || (cnt_next == CNT_MAX)) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = ptr_after(sel);
        trunc_d  = !req_if.req_last[sel];
      end else begin
        state_d  = ARB_LOCKED;
        owner_d  = sel;
      end
    end
  end

  assign req_if.req_ready = ready;
  assign fifo_wr_en       = xfer;
  assign fifo_din         = {sel, req_if.req_data[int'(sel)*WIDTH +: WIDTH]};
  assign grant_id         = grant_q;
  assign locked           = (state_q == ARB_LOCKED);
  assign burst_trunc      = trunc_q;

  // Arbitration state; a reset drops any lock and holds the port off for one edge
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
      en_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a depth-8 FIFO model
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [9:0] fifo_din;
  logic [1:0] grant_id;
  logic       locked;
  logic       burst_trunc;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) req_if ();

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .req_if      (req_if),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .grant_id    (grant_id),
    .locked      (locked),
    .burst_trunc (burst_trunc)
  );

  logic [11:0] pq [N][$];
  int          gap_left [N];
  logic [9:0]  sb [$];
  logic [9:0]  fq [$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        rd_en = 1'b1;

  logic        obs_wr, obs_locked, obs_trunc;
  logic [N-1:0] obs_ready, obs_valid;
  logic [9:0]  obs_din;
  logic [1:0]  obs_gid;
  logic [1:0]  last_id = 2'd0;
  int          trunc_seen = 0;
  int          lock_seen = 0;
  int          wr_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic load(input int p, input logic [7:0] d, input logic last, input int gap);
    pq[p].push_back({gap[2:0], last, d});
    if (pq[p].size() == 1) gap_left[p] = gap;
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    sb.push_back({id[1:0], d});
  endtask

  task automatic drive();
    logic [11:0] h;
    for (int i = 0; i < N; i++) begin
      h = (pq[i].size() > 0) ? pq[i][0] : 12'd0;
      req_if.req_valid[i]       = (pq[i].size() > 0) && (gap_left[i] == 0);
      req_if.req_last[i]        = h[8];
      req_if.req_data[i*W +: W] = h[7:0];
    end
    fifo_full = (fq.size() >= DEPTH);
  endtask

  task automatic cycle();
    logic [11:0] h;
    @(negedge clk);
    obs_wr     = fifo_wr_en;
    obs_locked = locked;
    obs_trunc  = burst_trunc;
    obs_ready  = req_if.req_ready;
    obs_valid  = req_if.req_valid;
    obs_din    = fifo_din;
    obs_gid    = grant_id;
    check("ready_onehot", 32'($countones(obs_ready) <= 1), 32'd1);
    check("wr_en_eq_xfer", 32'(obs_wr), 32'(|(obs_valid & obs_ready)));
    check("wr_while_full", 32'(obs_wr & fifo_full), 32'd0);
    check("grant_id", 32'(obs_gid), 32'(last_id));
    if (obs_trunc) trunc_seen++;
    if (obs_locked) lock_seen++;
    if (obs_wr) begin
      wr_seen++;
      for (int i = 0; i < N; i++) if (obs_ready[i]) last_id = 2'(i);
      if (sb.size() == 0) check("sb_extra_write", 32'(sb.size()), 32'd1);
      else check("fifo_din", 32'(obs_din), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
    if (rd_en && fq.size() > 0) void'(fq.pop_front());
    if (obs_wr) fq.push_back(obs_din);
    check("fifo_count_le_depth", 32'(fq.size() <= DEPTH), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (obs_valid[i] && obs_ready[i]) begin
        void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          h = pq[i][0];
          gap_left[i] = int'(h[11:9]);
        end
      end else if (gap_left[i] > 0) begin
        gap_left[i]--;
      end
    end
    drive();
  endtask

  task automatic run_until_empty(input string tag, input int max_cycles);
    int k = 0;
    while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() + sb.size()) > 0
           && k < max_cycles) begin
      cycle();
      k++;
    end
    check({tag, "_done"}, 32'(k < max_cycles), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic drain_fifo();
    int k = 0;
    rd_en = 1'b1;
    while (fq.size() > 0 && k < 20) begin
      cycle();
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) gap_left[i] = 0;
    // Test 1: all four valid with single-beat packets
    load(0, 8'h10, 1'b1, 0); load(1, 8'hA5, 1'b1, 0);
    load(2, 8'h22, 1'b1, 0); load(3, 8'h33, 1'b1, 0);
    load(0, 8'h40, 1'b1, 0);
    push_exp(0, 8'h10); push_exp(1, 8'hA5); push_exp(2, 8'h22);
    push_exp(3, 8'h33); push_exp(0, 8'h40);
    drive();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_if.req_ready), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_trunc", 32'(burst_trunc), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    cycle();
    check("t1_first_ready", 32'(obs_ready), 32'd0);
    run_until_empty("t1", 20);

    // Test 2: req1 3-beat packet stays contiguous, then req2, then req0
    lock_seen = 0;
    load(1, 8'hB1, 1'b0, 0); load(1, 8'hB2, 1'b0, 0); load(1, 8'hB3, 1'b1, 0);
    load(0, 8'hD0, 1'b1, 0); load(2, 8'hC2, 1'b1, 0);
    push_exp(1, 8'hB1); push_exp(1, 8'hB2); push_exp(1, 8'hB3);
    push_exp(2, 8'hC2); push_exp(0, 8'hD0);
    drive();
    run_until_empty("t2", 20);
    check("t2_lock_cycles", 32'(lock_seen), 32'd2);

    // Test 3: req3 forced release after MAX_BURST beats, req0 served, then remainder
    trunc_seen = 0;
    for (int b = 0; b < 6; b++) load(3, 8'hE0 + 8'(b), (b == 5), 0);
    load(0, 8'hF0, 1'b1, 0);
    for (int b = 0; b < 4; b++) push_exp(3, 8'hE0 + 8'(b));
    push_exp(0, 8'hF0); push_exp(3, 8'hE4); push_exp(3, 8'hE5);
    drive();
    run_until_empty("t3", 30);
    check("t3_trunc_pulses", 32'(trunc_seen), 32'd1);

    // Test 4: fill the FIFO, verify backpressure, one read lets exactly one beat in
    drain_fifo();
    rd_en = 1'b0;
    for (int b = 0; b < 10; b++) begin
      load(0, 8'h50 + 8'(b), 1'b1, 0);
      push_exp(0, 8'h50 + 8'(b));
    end
    drive();
    for (int k = 0; k < 20 && fq.size() < DEPTH; k++) cycle();
    check("t4_fifo_filled", 32'(fq.size()), 32'(DEPTH));
    repeat (3) begin
      cycle();
      check("t4_full_wr_en", 32'(obs_wr), 32'd0);
      check("t4_full_ready", 32'(obs_ready), 32'd0);
    end
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    wr_seen = 0;
    repeat (4) cycle();
    check("t4_one_beat_after_read", 32'(wr_seen), 32'd1);
    check("t4_count_after", 32'(fq.size()), 32'(DEPTH));
    rd_en = 1'b1;
    run_until_empty("t4", 30);

    // Test 5: reset asserted while req2 holds the lock
    drain_fifo();
    load(2, 8'h71, 1'b0, 0); load(2, 8'h72, 1'b0, 0); load(2, 8'h73, 1'b0, 0);
    push_exp(2, 8'h71);
    drive();
    for (int k = 0; k < 10 && pq[2].size() > 2; k++) cycle();
    check("t5_locked_before", 32'(locked), 32'd1);
    arst_n = 1'b0;
    #1;
    check("t5_rst_locked", 32'(locked), 32'd0);
    check("t5_rst_ready", 32'(req_if.req_ready), 32'd0);
    check("t5_rst_grant_id", 32'(grant_id), 32'd0);
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      gap_left[i] = 0;
    end
    sb.delete();
    fq.delete();
    last_id = 2'd0;
    load(2, 8'h81, 1'b1, 0); load(0, 8'h80, 1'b1, 0);
    push_exp(0, 8'h80); push_exp(2, 8'h81);
    drive();
    @(posedge clk);
    #1 arst_n = 1'b1;
    cycle();
    check("t5_first_ready", 32'(obs_ready), 32'd0);
    cycle();
    check("t5_req0_granted", 32'(obs_ready), 32'b0001);
    run_until_empty("t5", 20);

    // Test 6: owner bubbles for 3 cycles while locked; others must wait
    load(3, 8'h91, 1'b0, 0); load(3, 8'h92, 1'b0, 3); load(3, 8'h93, 1'b1, 0);
    load(0, 8'h90, 1'b1, 0);
    push_exp(3, 8'h91); push_exp(3, 8'h92); push_exp(3, 8'h93); push_exp(0, 8'h90);
    drive();
    for (int k = 0; k < 10 && pq[3].size() > 2; k++) cycle();
    repeat (3) begin
      cycle();
      check("t6_lock_held", 32'(obs_locked), 32'd1);
      check("t6_no_wr", 32'(obs_wr), 32'd0);
      check("t6_req0_wait", 32'(obs_ready[0]), 32'd0);
    end
    run_until_empty("t6", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
